// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Width of a counter that must reach 'settle'; never narrower than one bit.
    function automatic int cnt_width(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/truth_table_scanner_timer.sv
// Settle counter: counts 0..SETTLE while enabled and flags the sample cycle.
module scan_settle_timer
    import scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(SETTLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(SETTLE));

    // Next count: clear wins, otherwise wrap to zero on the sample cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input code of a small combinational block, waits the settle
// time per code, and records the truth table plus summary statistics.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [NUM_IN-1:0]    vec_out,
    input  logic                 dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**NUM_IN-1:0] table_out,
    output logic [NUM_IN:0]      ones_cnt,
    output logic                 hit_any,
    output logic [NUM_IN-1:0]    first_hit
);

    scan_state_t         state_q, state_d;
    logic [NUM_IN-1:0]    vec_q, vec_d;
    logic [2**NUM_IN-1:0] tbl_q, tbl_d;
    logic [NUM_IN:0]      ones_q, ones_d;
    logic                 hit_q, hit_d;
    logic [NUM_IN-1:0]    first_q, first_d;

    logic start_acc;
    logic tick;

    assign start_acc = (state_q == IDLE) && start;

    scan_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == SCAN),
        .clr  (start_acc),
        .tick (tick)
    );

    // FSM next state, vector stepping and result accumulation.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tbl_d   = tbl_q;
        ones_d  = ones_q;
        hit_d   = hit_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    vec_d   = '0;
                    tbl_d   = '0;
                    ones_d  = '0;
                    hit_d   = 1'b0;
                    first_d = '0;
                end
            end
            SCAN: begin
                if (tick) begin
                    tbl_d[vec_q] = dut_in;
                    ones_d       = ones_q + (NUM_IN + 1)'(dut_in);
                    if (dut_in && !hit_q) begin
                        hit_d   = 1'b1;
                        first_d = vec_q;
                    end
                    // Natural wrap returns the vector to 0 on the last code.
                    vec_d = vec_q + NUM_IN'(1);
                    if (vec_q == {NUM_IN{1'b1}}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            tbl_q   <= '0;
            ones_q  <= '0;
            hit_q   <= 1'b0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tbl_q   <= tbl_d;
            ones_q  <= ones_d;
            hit_q   <= hit_d;
            first_q <= first_d;
        end
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign table_out = tbl_q;
    assign ones_cnt  = ones_q;
    assign hit_any   = hit_q;
    assign first_hit = first_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: three scanners (SETTLE 0, 1, 3) each drive a lookup-table
// DUT; expected results are queued at scan issue and checked when done pulses.
module tb_truth_table_scanner;

    typedef struct {
        int          k;
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        hit;
        logic [3:0]  first;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a  [3];
    logic [3:0]  vec_a    [3];
    logic        dut_in_a [3];
    logic        busy_a   [3];
    logic        done_a   [3];
    logic [15:0] tbl_a    [3];
    logic [4:0]  ones_a   [3];
    logic        hit_a    [3];
    logic [3:0]  first_a  [3];
    logic [15:0] tt_a     [3];
    int          done_cnt [3];
    int          S [3] = '{0, 1, 3};

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Combinational DUTs: response is the truth-table bit for the driven code.
    always_comb begin
        for (int k = 0; k < 3; k++) dut_in_a[k] = tt_a[k][vec_a[k]];
    end

    truth_table_scanner #(.NUM_IN(4), .SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .vec_out(vec_a[0]), .dut_in(dut_in_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .table_out(tbl_a[0]), .ones_cnt(ones_a[0]),
        .hit_any(hit_a[0]), .first_hit(first_a[0]));
    truth_table_scanner #(.NUM_IN(4), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .vec_out(vec_a[1]), .dut_in(dut_in_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .table_out(tbl_a[1]), .ones_cnt(ones_a[1]),
        .hit_any(hit_a[1]), .first_hit(first_a[1]));
    truth_table_scanner #(.NUM_IN(4), .SETTLE(3)) u2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .vec_out(vec_a[2]), .dut_in(dut_in_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .table_out(tbl_a[2]), .ones_cnt(ones_a[2]),
        .hit_any(hit_a[2]), .first_hit(first_a[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk all codes of the function's table and summarise.
    function automatic res_t model(input int k, input logic [15:0] tt);
        res_t r;
        r.k = k; r.tbl = 16'h0; r.ones = 5'd0; r.hit = 1'b0; r.first = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (tt[i]) begin
                r.tbl[i] = 1'b1;
                r.ones   = r.ones + 5'd1;
                if (!r.hit) begin
                    r.hit   = 1'b1;
                    r.first = 4'(i);
                end
            end
        end
        return r;
    endfunction

    // Monitor: pops the expected result whenever a scanner presents done.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_a[k] === 1'b1) begin
                done_cnt[k]++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: inst %0d got done with no scan pending", k);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("result_inst", k, e.k);
                    chk("table_out", tbl_a[k], e.tbl);
                    chk("ones_cnt", ones_a[k], e.ones);
                    chk("hit_any", hit_a[k], e.hit);
                    chk("first_hit", first_a[k], e.first);
                end
            end
        end
    end

    task automatic run_scan(input int k, input logic [15:0] tt, input int poke);
        int         cyc, run_len, dn0;
        logic [3:0] pv;
        bit         poked;
        tt_a[k] = tt;
        exp_q.push_back(model(k, tt));
        dn0 = done_cnt[k];
        @(negedge clk); start_a[k] = 1'b1;
        @(posedge clk); #1 start_a[k] = 1'b0;
        chk("busy_after_start", busy_a[k], 1);
        chk("vec_first", vec_a[k], 0);
        cyc = 0; run_len = 1; pv = vec_a[k]; poked = 0;
        while (cyc < 400) begin
            @(posedge clk); #1 cyc++;
            start_a[k] = 1'b0;
            if (done_a[k]) break;
            if (vec_a[k] != pv) begin
                chk("vec_hold", run_len, S[k] + 1);
                chk("vec_step", vec_a[k], pv + 4'd1);
                run_len = 1;
                pv = vec_a[k];
            end else begin
                run_len++;
            end
            if (poke >= 0 && !poked && vec_a[k] == 4'(poke)) begin
                start_a[k] = 1'b1;
                poked = 1;
            end
        end
        chk("done_latency", cyc, 16 * (S[k] + 1));
        chk("busy_in_done", busy_a[k], 0);
        chk("vec_zero_done", vec_a[k], 0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt[k] - dn0, 1);
        chk("idle_busy", busy_a[k], 0);
    endtask

    task automatic abort_scan(input int k, input logic [15:0] tt);
        int cyc;
        tt_a[k] = tt;
        exp_q.push_back(model(k, tt));
        @(negedge clk); start_a[k] = 1'b1;
        @(posedge clk); #1 start_a[k] = 1'b0;
        cyc = 0;
        while (vec_a[k] != 4'd9 && cyc < 400) begin
            @(posedge clk); #1 cyc++;
        end
        chk("reach_vec9", vec_a[k], 9);
        void'(exp_q.pop_back());
        #2 rst = 1'b1;
        #1;
        chk("rst_vec", vec_a[k], 0);
        chk("rst_busy", busy_a[k], 0);
        chk("rst_done", done_a[k], 0);
        chk("rst_table", tbl_a[k], 0);
        chk("rst_ones", ones_a[k], 0);
        chk("rst_hit", hit_a[k], 0);
        chk("rst_first", first_a[k], 0);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic back_to_back(input int k);
        int cyc, last, n;
        tt_a[k] = 16'($urandom);
        exp_q.push_back(model(k, tt_a[k]));
        @(negedge clk); start_a[k] = 1'b1;
        cyc = 0; last = 0; n = 0;
        while (n < 3 && cyc < 2000) begin
            @(posedge clk); #1 cyc++;
            if (done_a[k]) begin
                if (n > 0) chk("b2b_spacing", cyc - last, 16 * (S[k] + 1) + 2);
                last = cyc;
                n++;
                if (n < 3) begin
                    tt_a[k] = 16'($urandom);
                    exp_q.push_back(model(k, tt_a[k]));
                end else begin
                    start_a[k] = 1'b0;
                end
            end
        end
        start_a[k] = 1'b0;
        chk("b2b_scans", n, 3);
        repeat (4) @(posedge clk);
        #1 chk("b2b_idle", busy_a[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] det, par;
        int wait_cyc;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0; tt_a[k] = 16'h0; done_cnt[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            det[i] = (iv == 4'b1110);
            par[i] = ^iv;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_vec", vec_a[k], 0);
            chk("reset_busy", busy_a[k], 0);
            chk("reset_done", done_a[k], 0);
            chk("reset_table", tbl_a[k], 0);
            chk("reset_ones", ones_a[k], 0);
            chk("reset_hit_first", {hit_a[k], first_a[k]}, 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_scan(1, det, -1);
        run_scan(0, 16'h0000, -1);
        run_scan(0, 16'hFFFF, -1);
        run_scan(2, par, -1);
        run_scan(1, 16'($urandom), 5);
        abort_scan(1, 16'($urandom));
        run_scan(1, 16'($urandom), -1);
        back_to_back(1);
        for (int r = 0; r < 3; r++) begin
            run_scan(0, 16'($urandom), -1);
            run_scan(2, 16'($urandom), -1);
        end
        run_scan(1, 16'h8000, -1);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 100) begin
            @(posedge clk); wait_cyc++;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
